// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Loads (or verifies) the serial configuration chain of switch boxes.
//   Bitstream words arrive over a valid/ready handshake and are shifted
//   LSB-first into the head of the chain, one bit per enabled clock.
//   In verify mode the same bitstream is re-shifted. Each bit that enters
//   the chain is compared with the bit leaving its tail. The first
//   mismatching bit index is captured.
//
// Ports
//   config_clk    in   clock shared with the chain
//   config_rst_n  in   asynchronous active-low reset
//   start         in   pulse that begins a pass (only honoured in IDLE)
//   verify        in   sampled with start: 0 = load, 1 = verify
//   word_data     in   next bitstream word, bit 0 shifted first
//   word_valid    in   word_data valid
//   word_ready    out  word_data accepted this cycle when also valid
//   chain_in      out  to config_in of box 0
//   chain_en      out  to config_en of every box
//   chain_out     in   from config_out of the last box
//   busy          out  pass in progress
//   done          out  one-cycle pulse at the end of a pass
//   error         out  sticky verify mismatch, cleared by an accepted start
//   err_idx       out  bit index of the first verify mismatch
module config_chain_loader #(
  parameter int CONFIG_WIDTH = 40,
  parameter int NUM_BOXES    = 4,
  parameter int WORD_WIDTH   = 8,
  localparam int CHAIN_LEN   = CONFIG_WIDTH * NUM_BOXES,
  localparam int IDX_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
  input  logic                  config_clk,
  input  logic                  config_rst_n,
  input  logic                  start,
  input  logic                  verify,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_in,
  output logic                  chain_en,
  input  logic                  chain_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_idx
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SH_W  = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]       sh_cnt_q, sh_cnt_d;
  logic [SH_W-1:0]       sh_len_q, sh_len_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  chain_in_q, chain_in_d;
  logic                  chain_en_q, chain_en_d;
  logic                  error_q, error_d;
  logic [IDX_W-1:0]      err_idx_q, err_idx_d;
  logic                  last_bit;

  // Bits to shift from the word being fetched: a full word, or only the
  // remainder of the chain when the final word is partial.
  function automatic logic [SH_W-1:0] word_len(input logic [CNT_W-1:0] shifted);
    logic [31:0] remain;
    remain = 32'(CHAIN_LEN) - 32'(shifted);
    if (remain < 32'(WORD_WIDTH)) begin
      word_len = SH_W'(remain);
    end else begin
      word_len = SH_W'(WORD_WIDTH);
    end
  endfunction

  // State register
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control registers. chain_en and chain_in are registered so the chain
  // sees clean levels. Reset drops chain_en at once, even mid-pass.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      mode_q     <= 1'b0;
      bit_cnt_q  <= '0;
      sh_cnt_q   <= '0;
      sh_len_q   <= '0;
      chain_in_q <= 1'b0;
      chain_en_q <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_len_q   <= sh_len_d;
      chain_in_q <= chain_in_d;
      chain_en_q <= chain_en_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // Word shift register. Bit 0 of the word goes straight to chain_in_q, so
  // this register only holds the bits still waiting to be presented.
  always_ff @(posedge config_clk) begin
    shreg_q <= shreg_d;
  end

  assign last_bit = ((sh_cnt_q + SH_W'(1)) == sh_len_q);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    sh_cnt_d   = sh_cnt_q;
    sh_len_d   = sh_len_q;
    shreg_d    = shreg_q;
    chain_in_d = chain_in_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          mode_d    = verify;
          bit_cnt_d = '0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end

      ST_FETCH: begin
        if (word_valid) begin
          state_d    = ST_SHIFT;
          chain_in_d = word_data[0];
          shreg_d    = word_data >> 1;
          sh_cnt_d   = '0;
          sh_len_d   = word_len(bit_cnt_q);
        end
      end

      ST_SHIFT: begin
        // chain_en is high for this whole state: the chain takes chain_in_q
        // on this edge. Bits above sh_len in a partial word never reach
        // chain_in.
        chain_in_d = shreg_q[0];
        shreg_d    = shreg_q >> 1;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        sh_cnt_d   = sh_cnt_q + SH_W'(1);

        // After a full load, the k-th shift of the next pass pushes the old
        // bit k out of the tail. That bit must equal the new bit k.
        if (mode_q && !error_q && (chain_out != chain_in_q)) begin
          error_d   = 1'b1;
          err_idx_d = bit_cnt_q[IDX_W-1:0];
        end

        if (last_bit) begin
          state_d = ((bit_cnt_q + CNT_W'(1)) == CHAIN_LEN_C) ? ST_DONE : ST_FETCH;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // chain_en tracks the SHIFT state one register stage ahead. This keeps it
  // aligned with chain_in_q.
  always_comb begin
    chain_en_d = (state_d == ST_SHIFT);
  end

  // Outputs
  always_comb begin
    word_ready = (state_q == ST_FETCH);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    chain_in   = chain_in_q;
    chain_en   = chain_en_q;
    error      = error_q;
    err_idx    = err_idx_q;
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader. Instance A drives an 80-bit chain
// (2 boxes x 40 bits), and instance B drives a 36-bit chain (1 box x 36 bits).
// Each chain is modelled as a plain shift register clocked when chain_en is high.
module tb_config_chain_loader;

  localparam int L   = 80;
  localparam int NW  = 10;
  localparam int LB  = 36;
  localparam int NWB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start_a, verify_a, word_valid_a, word_ready_a;
  logic       chain_in_a, chain_en_a, chain_out_a, busy_a, done_a, error_a;
  logic [7:0] word_data_a;
  logic [6:0] err_idx_a;

  logic       start_b, verify_b, word_valid_b, word_ready_b;
  logic       chain_in_b, chain_en_b, chain_out_b, busy_b, done_b, error_b;
  logic [7:0] word_data_b;
  logic [5:0] err_idx_b;

  config_chain_loader #(.CONFIG_WIDTH(40), .NUM_BOXES(2), .WORD_WIDTH(8)) dut_a (
    .config_clk(clk), .config_rst_n(rst_n), .start(start_a), .verify(verify_a),
    .word_data(word_data_a), .word_valid(word_valid_a), .word_ready(word_ready_a),
    .chain_in(chain_in_a), .chain_en(chain_en_a), .chain_out(chain_out_a),
    .busy(busy_a), .done(done_a), .error(error_a), .err_idx(err_idx_a)
  );

  config_chain_loader #(.CONFIG_WIDTH(36), .NUM_BOXES(1), .WORD_WIDTH(8)) dut_b (
    .config_clk(clk), .config_rst_n(rst_n), .start(start_b), .verify(verify_b),
    .word_data(word_data_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
    .chain_in(chain_in_b), .chain_en(chain_en_b), .chain_out(chain_out_b),
    .busy(busy_b), .done(done_b), .error(error_b), .err_idx(err_idx_b)
  );

  // Chain models: new bit enters at [0], and the tail is the top bit.
  logic [L-1:0]  chain_a = '0;
  logic [LB-1:0] chain_b = '0;
  always @(posedge clk) begin
    if (chain_en_a) chain_a <= {chain_a[L-2:0], chain_in_a};
    if (chain_en_b) chain_b <= {chain_b[LB-2:0], chain_in_b};
  end
  assign chain_out_a = chain_a[L-1];
  assign chain_out_b = chain_b[LB-1];

  // Free-running event counters; passes take differences.
  int cyc = 0, en_a = 0, done_a_cnt = 0, done_cyc_a = 0;
  int en_b = 0, acc_b = 0, done_b_cnt = 0, done_cyc_b = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chain_en_a) en_a <= en_a + 1;
    if (done_a) begin done_a_cnt <= done_a_cnt + 1; done_cyc_a <= cyc; end
    if (chain_en_b) en_b <= en_b + 1;
    if (word_valid_b && word_ready_b) acc_b <= acc_b + 1;
    if (done_b) begin done_b_cnt <= done_b_cnt + 1; done_cyc_b <= cyc; end
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s: timed out, expected event never came", nm);
  endtask

  // Reference model: after CHAIN_LEN shifts, stream bit k sits k places from
  // the tail.
  function automatic logic [L-1:0] image_of(input logic [L-1:0] s);
    logic [L-1:0] img;
    for (int k = 0; k < L; k++) img[L-1-k] = s[k];
    return img;
  endfunction

  function automatic int first_diff(input logic [L-1:0] a, input logic [L-1:0] b);
    for (int k = 0; k < L; k++) if (a[k] != b[k]) return k;
    return -1;
  endfunction

  logic [L-1:0] prev_stream;

  // Offer one word to A, optionally with a valid gap of 'gap' FETCH cycles.
  task automatic send_word(input logic [7:0] d, input int gap);
    int to;
    if (gap > 0) begin
      word_valid_a = 1'b0;
      to = 0;
      while (!word_ready_a && to < 100) begin @(negedge clk); to++; end
      if (!word_ready_a) timeout("gap_wait_ready");
      for (int i = 0; i < gap; i++) begin
        chk("gap_chain_en", L'(chain_en_a), L'(0));
        @(negedge clk);
      end
    end
    word_data_a  = d;
    word_valid_a = 1'b1;
    to = 0;
    while (!word_ready_a && to < 100) begin @(negedge clk); to++; end
    if (!word_ready_a) timeout("word_handshake");
    @(negedge clk);
  endtask

  task automatic run_pass(input string tag, input bit vfy, input logic [L-1:0] s,
                          input logic [NW-1:0] gaps, input int glitch,
                          input bit exp_err, input int exp_idx, input int exp_lat);
    int en0, dn0, scyc, to;
    en0 = en_a;
    dn0 = done_a_cnt;
    verify_a = vfy;
    start_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    scyc = cyc - 1;
    chk({tag, "_busy_on"}, L'(busy_a), L'(1));
    for (int w = 0; w < NW; w++) begin
      send_word(s[8*w +: 8], gaps[w] ? 3 : 0);
      if (w == glitch) begin
        start_a  = 1'b1;
        verify_a = ~vfy;
        @(negedge clk);
        start_a  = 1'b0;
        verify_a = vfy;
      end
    end
    word_valid_a = 1'b0;
    to = 0;
    while (done_a_cnt == dn0 && to < 300) begin @(negedge clk); to++; end
    if (done_a_cnt == dn0) timeout({tag, "_done"});
    chk({tag, "_busy_off"}, L'(busy_a), L'(0));
    @(negedge clk);
    chk({tag, "_done_pulses"}, L'(done_a_cnt - dn0), L'(1));
    chk({tag, "_en_cycles"}, L'(en_a - en0), L'(L));
    chk({tag, "_latency"}, L'(done_cyc_a - scyc), L'(exp_lat));
    chk({tag, "_error"}, L'(error_a), L'(exp_err));
    chk({tag, "_err_idx"}, L'(err_idx_a), L'(exp_idx));
    chk({tag, "_image"}, chain_a, image_of(s));
    prev_stream = s;
  endtask

  typedef struct {
    bit           vfy;
    logic [L-1:0] flip;
    logic [NW-1:0] gaps;
    int           glitch;
    bit           exp_err;
    int           exp_idx;
    int           exp_lat;
  } vec_t;

  vec_t tbl[5];
  logic [L-1:0] base;

  initial begin
    base = {40'h0C300F0000, 40'h0C300F0000};
    // The pass latency is counted from the start edge to the edge that
    // samples done. This gives CHAIN_LEN + words + 1 plus any gap cycles.
    tbl[0] = '{1'b0, '0, '0, -1, 1'b0, 0, 91};
    tbl[1] = '{1'b1, '0, '0, -1, 1'b0, 0, 91};
    tbl[2] = '{1'b1, (80'd1 << 17) | (80'd1 << 60), '0, -1, 1'b1, 17, 91};
    tbl[3] = '{1'b0, '0, 10'b0010001000, -1, 1'b0, 0, 97};
    tbl[4] = '{1'b1, '0, '0, 4, 1'b0, 0, 91};

    rst_n = 1'b0;
    start_a = 0; verify_a = 0; word_valid_a = 0; word_data_a = '0;
    start_b = 0; verify_b = 0; word_valid_b = 0; word_data_b = '0;
    prev_stream = '0;
    repeat (3) @(negedge clk);
    chk("rst_word_ready", L'(word_ready_a), L'(0));
    chk("rst_chain_in", L'(chain_in_a), L'(0));
    chk("rst_chain_en", L'(chain_en_a), L'(0));
    chk("rst_busy", L'(busy_a), L'(0));
    chk("rst_done", L'(done_a), L'(0));
    chk("rst_error", L'(error_a), L'(0));
    chk("rst_err_idx", L'(err_idx_a), L'(0));
    chk("rst_b_busy", L'(busy_b), L'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_pass($sformatf("vec%0d", i), tbl[i].vfy, base ^ tbl[i].flip, tbl[i].gaps,
               tbl[i].glitch, tbl[i].exp_err, tbl[i].exp_idx, tbl[i].exp_lat);
    end

    for (int r = 0; r < 8; r++) begin
      bit            vfy, ee;
      logic [L-1:0]  s, fl;
      logic [NW-1:0] g;
      int            nf, fd, ei;
      vfy = 1'($urandom_range(0, 1));
      if (vfy) begin
        fl = '0;
        nf = int'($urandom_range(0, 2));
        for (int j = 0; j < nf; j++) fl[$urandom_range(0, L-1)] = 1'b1;
        s = prev_stream ^ fl;
      end else begin
        s = L'({$urandom, $urandom, $urandom});
      end
      g  = NW'($urandom) & NW'($urandom) & NW'($urandom);
      fd = first_diff(s, prev_stream);
      ee = vfy && (fd >= 0);
      ei = ee ? fd : 0;
      run_pass($sformatf("rnd%0d", r), vfy, s, g, -1, ee, ei, L + NW + 1 + 3 * $countones(g));
    end

    // Reset in the middle of a load, then a fresh load.
    begin
      int en0, to;
      en0 = en_a;
      verify_a = 1'b0;
      start_a  = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      word_data_a  = 8'h5A;
      word_valid_a = 1'b1;
      to = 0;
      while ((en_a - en0) < 30 && to < 200) begin @(negedge clk); to++; end
      if ((en_a - en0) < 30) timeout("rst_mid_shift");
      chk("rst_mid_pre_en", L'(chain_en_a), L'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_chain_en", L'(chain_en_a), L'(0));
      chk("rst_mid_busy", L'(busy_a), L'(0));
      chk("rst_mid_word_ready", L'(word_ready_a), L'(0));
      chk("rst_mid_done", L'(done_a), L'(0));
      @(negedge clk);
      rst_n = 1'b1;
      word_valid_a = 1'b0;
      @(negedge clk);
      chk("rst_after_busy", L'(busy_a), L'(0));
      chk("rst_after_chain_en", L'(chain_en_a), L'(0));
      run_pass("post_rst", 1'b0, base, '0, -1, 1'b0, 0, 91);
    end

    // 36-bit chain: the last word is partial and shifts only 4 bits.
    begin
      logic [39:0]   rb;
      logic [LB-1:0] imgb;
      int            en0, a0, d0, scyc, to;
      rb  = 40'({$urandom, $urandom});
      en0 = en_b; a0 = acc_b; d0 = done_b_cnt;
      verify_b = 1'b0;
      start_b  = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      scyc = cyc - 1;
      for (int w = 0; w < NWB; w++) begin
        word_data_b  = rb[8*w +: 8];
        word_valid_b = 1'b1;
        to = 0;
        while (!word_ready_b && to < 50) begin @(negedge clk); to++; end
        if (!word_ready_b) timeout("b_handshake");
        @(negedge clk);
      end
      word_valid_b = 1'b0;
      to = 0;
      while (done_b_cnt == d0 && to < 100) begin @(negedge clk); to++; end
      if (done_b_cnt == d0) timeout("b_done");
      @(negedge clk);
      for (int k = 0; k < LB; k++) imgb[LB-1-k] = rb[k];
      chk("b_words_accepted", L'(acc_b - a0), L'(NWB));
      chk("b_en_cycles", L'(en_b - en0), L'(LB));
      chk("b_latency", L'(done_cyc_b - scyc), L'(LB + NWB + 1));
      chk("b_done_pulses", L'(done_b_cnt - d0), L'(1));
      chk("b_image", L'(chain_b), L'(imgb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
